// File: rtl/payload_stream_arbiter.sv
// Round-robin arbiter that buffers one fixed-length record per channel and
// streams it out as a sequence-stamped AXI-Stream packet.
module payload_stream_arbiter #(
  parameter int NUM_CH    = 10,
  parameter int DATA_W    = 256,
  parameter int REC_BYTES = 80,
  parameter int SEQ_OFS   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             ch_en,
  input  logic [NUM_CH*REC_BYTES*8-1:0] ch_rec,
  input  logic [31:0]                   seq_init,
  input  logic                          seq_load,
  input  logic                          tready,
  output logic [NUM_CH-1:0]             ch_ack,
  output logic [NUM_CH-1:0]             ovf,
  output logic                          tvalid,
  output logic                          tlast,
  output logic [DATA_W-1:0]             data,
  output logic [DATA_W/8-1:0]           tkeep,
  output logic [DATA_W/8-1:0]           tstrb,
  output logic                          fsm_state
);
  localparam int LANES      = DATA_W / 8;
  localparam int BEATS      = (REC_BYTES + LANES - 1) / LANES;
  localparam int REC_W      = REC_BYTES * 8;
  localparam int PKT_W      = BEATS * DATA_W;
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CH_W       = $clog2(NUM_CH);
  localparam int LAST_BYTES = REC_BYTES - (BEATS - 1) * LANES;
  localparam logic [LANES-1:0] KEEP_FULL = '1;
  localparam logic [LANES-1:0] KEEP_LAST = KEEP_FULL >> (LANES - LAST_BYTES);

  typedef enum logic {IDLE, SEND} state_t;

  // Handshake: a beat transfers on a rising edge where tvalid & tready;
  // data/tkeep/tlast are held while tvalid=1 and tready=0.
  state_t             state;
  logic [REC_W-1:0]   rec_buf [NUM_CH];
  logic [PKT_W-1:0]   pkt_q;
  logic [NUM_CH-1:0]  pending, pending_nxt, freeing, capture, cand;
  logic [CH_W-1:0]    last_grant, pick;
  logic               pick_valid, do_grant, hs, hs_last;
  logic [BEAT_W-1:0]  beat, nbeat;
  logic [31:0]        seq, seq_nxt, stamp;
  logic [REC_W-1:0]   rec_sel;
  logic [PKT_W-1:0]   pkt_new;
  int                 idx;

  assign hs          = tvalid & tready;
  assign hs_last     = hs & tlast;
  assign nbeat       = beat + 1'b1;
  assign capture     = ch_en & (~pending | freeing);
  assign pending_nxt = (pending & ~freeing) | capture;
  assign cand        = pending & ~freeing;
  assign do_grant    = pick_valid & ((state == IDLE) | hs_last);
  assign stamp       = hs_last ? seq_nxt : seq;
  assign tstrb       = tkeep;
  assign fsm_state   = (state == SEND);

  always_comb begin
    freeing = '0;
    if (hs_last) freeing[last_grant] = 1'b1;
  end

  always_comb begin
    seq_nxt = seq;
    if (seq_load)     seq_nxt = seq_init;
    else if (hs_last) seq_nxt = seq + 32'd1;
  end

  // Search starts just after the previous grant, so the last winner ranks lowest.
  always_comb begin
    pick_valid = 1'b0;
    pick       = last_grant;
    idx        = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(last_grant) + k) % NUM_CH;
      if (!pick_valid && cand[idx]) begin
        pick_valid = 1'b1;
        pick       = CH_W'(idx);
      end
    end
  end

  always_comb begin
    rec_sel = rec_buf[pick];
    for (int j = 0; j < 4; j++) rec_sel[(SEQ_OFS + j) * 8 +: 8] = stamp[(3 - j) * 8 +: 8];
    pkt_new = PKT_W'(rec_sel);
  end

  // Record storage carries no reset; validity lives entirely in pending.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++)
      if (capture[i]) rec_buf[i] <= ch_rec[i * REC_W +: REC_W];
    if (do_grant) pkt_q <= pkt_new;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= '0;
      ch_ack     <= '0;
      ovf        <= '0;
      seq        <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
      beat       <= '0;
      tvalid     <= 1'b0;
      tlast      <= 1'b0;
      data       <= '0;
      tkeep      <= '0;
    end else begin
      pending <= pending_nxt;
      ch_ack  <= capture;
      ovf     <= ovf | (ch_en & pending & ~freeing);
      seq     <= seq_nxt;
      if (do_grant) begin
        state      <= SEND;
        last_grant <= pick;
        beat       <= '0;
        tvalid     <= 1'b1;
        data       <= pkt_new[DATA_W-1:0];
        tlast      <= (BEATS == 1);
        tkeep      <= (BEATS == 1) ? KEEP_LAST : KEEP_FULL;
      end else if (hs_last) begin
        state  <= IDLE;
        tvalid <= 1'b0;
        tlast  <= 1'b0;
        data   <= '0;
        tkeep  <= '0;
      end else if (hs) begin
        beat  <= nbeat;
        data  <= pkt_q[nbeat * DATA_W +: DATA_W];
        tlast <= (nbeat == BEAT_W'(BEATS - 1));
        tkeep <= (nbeat == BEAT_W'(BEATS - 1)) ? KEEP_LAST : KEEP_FULL;
      end
    end
  end
endmodule
